// File: rtl/dbi_tx_arb.sv
// dbi_tx_arb: shares one DBI TX PHY command/data channel between two requesters.
//   m0_* : frame sequencer requester (vld/rdy handshake, payload typ/dat/last/no_dat/hrst)
//   m1_* : software command requester (same handshake/payload as m0)
//   dtp_*: PHY side, driven from the head of a 2-entry registered skid slice
//   arb_busy_o  : a grant is currently held
//   arb_owner_o : current (or most recent) grant owner
// Grants are round-robin and held for a whole transaction. A transaction ends on an
// accepted owner beat carrying last, no_dat or hrst.
module dbi_tx_arb #(
    parameter int unsigned DBI_IF_D_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DBI_IF_D_W-1:0] m0_tx_cmd_typ_i,
    input  logic [DBI_IF_D_W-1:0] m0_tx_cmd_dat_i,
    input  logic                  m0_tx_last_i,
    input  logic                  m0_tx_no_dat_i,
    input  logic                  m0_dbi_hrst_i,
    input  logic                  m0_tx_vld_i,
    output logic                  m0_tx_rdy_o,
    input  logic [DBI_IF_D_W-1:0] m1_tx_cmd_typ_i,
    input  logic [DBI_IF_D_W-1:0] m1_tx_cmd_dat_i,
    input  logic                  m1_tx_last_i,
    input  logic                  m1_tx_no_dat_i,
    input  logic                  m1_dbi_hrst_i,
    input  logic                  m1_tx_vld_i,
    output logic                  m1_tx_rdy_o,
    input  logic                  dtp_tx_rdy_i,
    output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o,
    output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o,
    output logic                  dtp_tx_last_o,
    output logic                  dtp_tx_no_dat_o,
    output logic                  dtp_dbi_hrst_o,
    output logic                  dtp_tx_vld_o,
    output logic                  arb_busy_o,
    output logic                  arb_owner_o
);

    localparam logic [0:0] ARB_ST = 1'b0;
    localparam logic [0:0] GNT_ST = 1'b1;

    typedef struct packed {
        logic [DBI_IF_D_W-1:0] typ;
        logic [DBI_IF_D_W-1:0] dat;
        logic                  last;
        logic                  no_dat;
        logic                  hrst;
    } beat_t;

    logic [0:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       m0_rdy_q, m0_rdy_d;
    logic       m1_rdy_q, m1_rdy_d;
    beat_t      e0_q, e0_d;
    beat_t      e1_q, e1_d;
    logic       v0_q, v0_d;
    logic       v1_q, v1_d;

    beat_t m0_beat;
    beat_t m1_beat;
    beat_t own_beat;
    logic  own_vld;
    logic  own_rdy;
    logic  push;
    logic  pop;
    logic  boundary;

    // Owner-side mux; rdy flops are only ever high in GNT_ST for the owner.
    always_comb begin
        m0_beat  = '{typ: m0_tx_cmd_typ_i, dat: m0_tx_cmd_dat_i, last: m0_tx_last_i,
                     no_dat: m0_tx_no_dat_i, hrst: m0_dbi_hrst_i};
        m1_beat  = '{typ: m1_tx_cmd_typ_i, dat: m1_tx_cmd_dat_i, last: m1_tx_last_i,
                     no_dat: m1_tx_no_dat_i, hrst: m1_dbi_hrst_i};
        own_beat = owner_q ? m1_beat : m0_beat;
        own_vld  = owner_q ? m1_tx_vld_i : m0_tx_vld_i;
        own_rdy  = owner_q ? m1_rdy_q : m0_rdy_q;
        push     = own_vld & own_rdy;
        pop      = v0_q & dtp_tx_rdy_i;
        boundary = own_beat.last | own_beat.no_dat | own_beat.hrst;
    end

    // Arbitration FSM: on a tie the requester that is not the last owner wins.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_ST: begin
                if (m0_tx_vld_i | m1_tx_vld_i) begin
                    state_d = GNT_ST;
                    owner_d = (m0_tx_vld_i & m1_tx_vld_i) ? ~owner_q : m1_tx_vld_i;
                end
            end
            GNT_ST: begin
                if (push & boundary) begin
                    state_d = ARB_ST;
                end
            end
            default: state_d = ARB_ST;
        endcase
    end

    // Skid slice: e0 is the head; push and pop together only happen with one entry held.
    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        case ({push, pop})
            2'b10: begin
                if (!v0_q) begin
                    e0_d = own_beat;
                    v0_d = 1'b1;
                end else begin
                    e1_d = own_beat;
                    v1_d = 1'b1;
                end
            end
            2'b01: begin
                e0_d = e1_q;
                v0_d = v1_q;
                v1_d = 1'b0;
            end
            2'b11: begin
                e0_d = own_beat;
            end
            default: ;
        endcase
    end

    // Ready is registered by evaluating it against the next-cycle state and occupancy.
    always_comb begin
        m0_rdy_d = (state_d == GNT_ST) && !owner_d && !v1_d;
        m1_rdy_d = (state_d == GNT_ST) &&  owner_d && !v1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_ST;
            owner_q  <= 1'b1;
            m0_rdy_q <= 1'b0;
            m1_rdy_q <= 1'b0;
            e0_q     <= '0;
            e1_q     <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            m0_rdy_q <= m0_rdy_d;
            m1_rdy_q <= m1_rdy_d;
            e0_q     <= e0_d;
            e1_q     <= e1_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
        end
    end

    assign m0_tx_rdy_o      = m0_rdy_q;
    assign m1_tx_rdy_o      = m1_rdy_q;
    assign dtp_tx_cmd_typ_o = e0_q.typ;
    assign dtp_tx_cmd_dat_o = e0_q.dat;
    assign dtp_tx_last_o    = e0_q.last;
    assign dtp_tx_no_dat_o  = e0_q.no_dat;
    assign dtp_dbi_hrst_o   = e0_q.hrst;
    assign dtp_tx_vld_o     = v0_q;
    assign arb_busy_o       = (state_q == GNT_ST);
    assign arb_owner_o      = owner_q;

endmodule
